// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle control unit: FSM state encoding,
// ALUControl codes, datapath select codes, instruction field codes
// (Op, Cond, data-processing Funct[4:1]), the registered control-word
// struct and the ARM condition evaluator.
package mc_ctrl_pkg;

  // FSM states; codes 10-15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // ALUControl codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_EOR   = 4'b0100;
  localparam logic [3:0] ALU_PASSB = 4'b0101;

  // ResultSrc codes
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALUSrcB codes
  localparam logic [1:0] ALUB_REG  = 2'b00;
  localparam logic [1:0] ALUB_IMM  = 2'b01;
  localparam logic [1:0] ALUB_FOUR = 2'b10;

  // Op field codes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Cond field codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Data-processing opcodes in Funct[4:1]
  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_EOR = 4'b0001;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_CMP = 4'b1010;
  localparam logic [3:0] DP_ORR = 4'b1100;
  localparam logic [3:0] DP_MOV = 4'b1101;

  // One registered control word; everything the datapath sees from the FSM
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
  } ctrl_t;

  // FETCH control word, also the value held while in reset
  localparam ctrl_t FETCH_CTRL = '{
    pc_write:    1'b1,
    ir_write:    1'b1,
    mem_write:   1'b0,
    reg_write:   1'b0,
    adr_src:     1'b0,
    result_src:  RES_ALU,
    alu_src_a:   1'b1,
    alu_src_b:   ALUB_FOUR,
    alu_control: ALU_ADD
  };

  // ARM condition check against a registered NZCV value
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = ~c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = c & ~z;
      COND_LS: cond_eval = ~c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_cond.sv
// cond_unit
// Holds the architectural NZCV register and the per-instruction CondEx bit.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   cond              Cond field of the current instruction
//   alu_flags         NZCV produced by the ALU this cycle
//   flag_we_nz        load N,Z from alu_flags at the next edge
//   flag_we_cv        load C,V from alu_flags at the next edge
//   latch_en          capture the condition result at the next edge (DECODE)
//   flags             registered NZCV
//   condex            latched CondEx for the instruction in flight
//   condex_next       value condex will hold after the next edge
module cond_unit
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       flag_we_nz,
  input  logic       flag_we_cv,
  input  logic       latch_en,
  output logic [3:0] flags,
  output logic       condex,
  output logic       condex_next
);

  logic [3:0] flags_q;
  logic       condex_q;
  logic       cond_true;

  // The condition is always judged against the registered flags, never the
  // live ALU flags, so it reflects only completed instructions.
  assign cond_true   = cond_eval(cond, flags_q);
  assign condex_next = latch_en ? cond_true : condex_q;

  // NZ and CV halves load independently so logical ops can leave C,V alone.
  // CondEx is captured once per instruction and then held, which keeps a
  // flag update in EXEC from changing the same instruction's writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      if (flag_we_nz) begin
        flags_q[3:2] <= alu_flags[3:2];
      end
      if (flag_we_cv) begin
        flags_q[1:0] <= alu_flags[1:0];
      end
      if (latch_en) begin
        condex_q <= cond_true;
      end
    end
  end

  assign flags  = flags_q;
  assign condex = condex_q;

endmodule

// File: rtl/mc_controller.sv
// mc_controller
// Multicycle control unit: 10-state FSM that sequences each instruction and
// drives every datapath select/enable, with ARM conditional execution
// applied to all architectural writes.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-low reset
//   ctrl_bits             {Cond[11:8], Op[7:6], Funct[5:0]}
//   rd                    destination register field
//   alu_flags             NZCV from the ALU this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite   write enables (0 while in reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB    datapath selects
//   RegSrc, ImmSrc        instruction-type selects derived from Op
//   ALUControl            ALU operation
//   Flags                 registered NZCV
//   state_dbg             current FSM state
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W   = 4,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [11:0]          ctrl_bits,
  input  logic [3:0]           rd,
  input  logic [3:0]           alu_flags,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [3:0]           Flags,
  output logic [STATE_W-1:0]   state_dbg
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;

  state_t     state;
  state_t     next_state;
  ctrl_t      ctrl_q;
  ctrl_t      ctrl_d;

  logic [3:0] dp_alu;
  logic       is_cmp;
  logic       dp_valid;
  logic       dp_logic;

  logic       in_exec;
  logic       flag_we_nz;
  logic       flag_we_cv;
  logic       latch_en;
  logic       condex;
  logic       condex_next;

  assign cond  = ctrl_bits[11:8];
  assign op    = ctrl_bits[7:6];
  assign funct = ctrl_bits[5:0];

  // Data-processing decode from Funct[4:1]. Logical ops and MOV only own
  // N,Z; CMP is a SUB that always sets flags and never writes a register;
  // unknown encodings run as ADD but must not write the register file.
  always_comb begin
    dp_alu   = ALU_ADD;
    is_cmp   = 1'b0;
    dp_valid = 1'b1;
    dp_logic = 1'b0;
    case (funct[4:1])
      DP_ADD: dp_alu = ALU_ADD;
      DP_SUB: dp_alu = ALU_SUB;
      DP_AND: begin
        dp_alu   = ALU_AND;
        dp_logic = 1'b1;
      end
      DP_ORR: begin
        dp_alu   = ALU_ORR;
        dp_logic = 1'b1;
      end
      DP_EOR: begin
        dp_alu   = ALU_EOR;
        dp_logic = 1'b1;
      end
      DP_MOV: begin
        dp_alu   = ALU_PASSB;
        dp_logic = 1'b1;
      end
      DP_CMP: begin
        dp_alu = ALU_SUB;
        is_cmp = 1'b1;
      end
      default: dp_valid = 1'b0;
    endcase
  end

  // Next-state logic; Op=11 is a NOP that returns straight to FETCH and any
  // unused state code recovers to FETCH.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  next_state = S_MEMADR;
          OP_DP:   next_state = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = S_MEMWB;
      S_EXECR:  next_state = S_ALUWB;
      S_EXECI:  next_state = S_ALUWB;
      default:  next_state = S_FETCH;
    endcase
  end

  // Control word for the state we are about to enter. It is registered with
  // the state, so it must use condex_next: on the DECODE exit edge CondEx is
  // being captured at the same time as this word.
  always_comb begin
    ctrl_d = '0;
    case (next_state)
      S_FETCH: ctrl_d = FETCH_CTRL;
      S_DECODE: begin
        ctrl_d.alu_src_a   = 1'b1;
        ctrl_d.alu_src_b   = ALUB_FOUR;
        ctrl_d.alu_control = ALU_ADD;
        ctrl_d.result_src  = RES_ALU;
      end
      S_MEMADR: begin
        ctrl_d.alu_src_b   = ALUB_IMM;
        ctrl_d.alu_control = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: ctrl_d.adr_src = 1'b1;
      S_MEMWB: begin
        ctrl_d.result_src = RES_DATA;
        ctrl_d.reg_write  = condex_next;
        ctrl_d.pc_write   = condex_next & (rd == 4'd15);
      end
      S_MEMWR: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = condex_next;
      end
      S_EXECR: begin
        ctrl_d.alu_src_b   = ALUB_REG;
        ctrl_d.alu_control = dp_alu;
      end
      S_EXECI: begin
        ctrl_d.alu_src_b   = ALUB_IMM;
        ctrl_d.alu_control = dp_alu;
      end
      S_ALUWB: begin
        ctrl_d.result_src = RES_ALUOUT;
        ctrl_d.reg_write  = condex_next & ~is_cmp & dp_valid;
        ctrl_d.pc_write   = condex_next & ~is_cmp & (rd == 4'd15);
      end
      S_BRANCH: begin
        ctrl_d.alu_src_b   = ALUB_IMM;
        ctrl_d.alu_control = ALU_ADD;
        ctrl_d.result_src  = RES_ALU;
        ctrl_d.pc_write    = condex_next;
      end
      default: ctrl_d = '0;
    endcase
  end

  // Single FSM register holding the state and its registered control word.
  // Reset drops any instruction in flight and parks on FETCH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_FETCH;
      ctrl_q <= FETCH_CTRL;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_d;
    end
  end

  // Flags are only written at the end of an EXEC cycle of an instruction
  // that passed its condition and either has S set or is a CMP.
  assign in_exec    = (state == S_EXECR) || (state == S_EXECI);
  assign flag_we_nz = in_exec & condex & (funct[0] | is_cmp);
  assign flag_we_cv = flag_we_nz & ~dp_logic;
  assign latch_en   = (state == S_DECODE);

  cond_unit u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond        (cond),
    .alu_flags   (alu_flags),
    .flag_we_nz  (flag_we_nz),
    .flag_we_cv  (flag_we_cv),
    .latch_en    (latch_en),
    .flags       (Flags),
    .condex      (condex),
    .condex_next (condex_next)
  );

  // Write enables are gated by reset directly so nothing is written during
  // a reset cycle, even one that arrives mid-instruction.
  assign PCWrite    = ctrl_q.pc_write  & reset;
  assign IRWrite    = ctrl_q.ir_write  & reset;
  assign MemWrite   = ctrl_q.mem_write & reset;
  assign RegWrite   = ctrl_q.reg_write & reset;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ALUControl = ALUCTRL_W'(ctrl_q.alu_control);
  assign RegSrc     = {op == OP_MEM, op == OP_BR};
  assign ImmSrc     = op;
  assign state_dbg  = STATE_W'(state);

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller
// Directed bench for mc_controller. Inputs change on the falling edge and
// outputs are compared 1 time unit later, mid-cycle.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ctrl_bits;
  logic [3:0]  rd;
  logic [3:0]  alu_flags;
  logic        PCWrite;
  logic        IRWrite;
  logic        MemWrite;
  logic        RegWrite;
  logic        AdrSrc;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  RegSrc;
  logic [1:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [3:0]  Flags;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // {Cond, Op, Funct} encodings
  localparam logic [11:0] ADD_R   = 12'hE08;
  localparam logic [11:0] LDR     = 12'hE59;
  localparam logic [11:0] SUBS_I  = 12'hE25;
  localparam logic [11:0] BEQ     = 12'h080;
  localparam logic [11:0] STRNE   = 12'h158;
  localparam logic [11:0] ADDSEQ  = 12'h009;
  localparam logic [11:0] CMP_R   = 12'hE14;
  localparam logic [11:0] ANDS_R  = 12'hE01;

  mc_controller #(.STATE_W(4), .ALUCTRL_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_bits  (ctrl_bits),
    .rd         (rd),
    .alu_flags  (alu_flags),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Wait for the falling edge, drive the next inputs, let them settle
  task automatic applyStimulus(input logic rst, input logic [11:0] c,
                               input logic [3:0] r, input logic [3:0] f);
    @(negedge clk);
    reset     = rst;
    ctrl_bits = c;
    rd        = r;
    alu_flags = f;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset     = 1'b0;
    ctrl_bits = ADD_R;
    rd        = 4'd3;
    alu_flags = 4'hF;

    // Reset held three cycles with a data-processing Op present
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, ADD_R, 4'd3, 4'hF);
      checkOutput("rst_state", 8'(state_dbg), 8'd0);
      checkOutput("rst_pcw", 8'(PCWrite), 8'd0);
      checkOutput("rst_irw", 8'(IRWrite), 8'd0);
      checkOutput("rst_mw", 8'(MemWrite), 8'd0);
      checkOutput("rst_rw", 8'(RegWrite), 8'd0);
      checkOutput("rst_flags", 8'(Flags), 8'h0);
    end

    // ADD r3 (register): 0,1,6,8; no S so Flags untouched
    applyStimulus(1'b1, ADD_R, 4'd3, 4'hF);
    checkOutput("add_fetch_state", 8'(state_dbg), 8'd0);
    checkOutput("add_fetch_pcw", 8'(PCWrite), 8'd1);
    checkOutput("add_fetch_irw", 8'(IRWrite), 8'd1);
    checkOutput("add_fetch_alub", 8'(ALUSrcB), 8'd2);
    checkOutput("add_fetch_rw", 8'(RegWrite), 8'd0);
    applyStimulus(1'b1, ADD_R, 4'd3, 4'hF);
    checkOutput("add_dec_state", 8'(state_dbg), 8'd1);
    checkOutput("add_dec_pcw", 8'(PCWrite), 8'd0);
    checkOutput("add_dec_rw", 8'(RegWrite), 8'd0);
    applyStimulus(1'b1, ADD_R, 4'd3, 4'hF);
    checkOutput("add_exec_state", 8'(state_dbg), 8'd6);
    checkOutput("add_exec_aluc", 8'(ALUControl), 8'h0);
    checkOutput("add_exec_alub", 8'(ALUSrcB), 8'd0);
    checkOutput("add_exec_rw", 8'(RegWrite), 8'd0);
    applyStimulus(1'b1, ADD_R, 4'd3, 4'hF);
    checkOutput("add_wb_state", 8'(state_dbg), 8'd8);
    checkOutput("add_wb_rw", 8'(RegWrite), 8'd1);
    checkOutput("add_wb_res", 8'(ResultSrc), 8'd0);
    checkOutput("add_wb_pcw", 8'(PCWrite), 8'd0);
    checkOutput("add_wb_flags", 8'(Flags), 8'h0);

    // LDR: 0,1,2,3,4
    applyStimulus(1'b1, LDR, 4'd5, 4'hF);
    checkOutput("ldr_fetch_state", 8'(state_dbg), 8'd0);
    checkOutput("ldr_fetch_regsrc", 8'(RegSrc), 8'd2);
    applyStimulus(1'b1, LDR, 4'd5, 4'hF);
    checkOutput("ldr_dec_state", 8'(state_dbg), 8'd1);
    applyStimulus(1'b1, LDR, 4'd5, 4'hF);
    checkOutput("ldr_adr_state", 8'(state_dbg), 8'd2);
    checkOutput("ldr_adr_alub", 8'(ALUSrcB), 8'd1);
    checkOutput("ldr_adr_aluc", 8'(ALUControl), 8'h0);
    applyStimulus(1'b1, LDR, 4'd5, 4'hF);
    checkOutput("ldr_rd_state", 8'(state_dbg), 8'd3);
    checkOutput("ldr_rd_adrsrc", 8'(AdrSrc), 8'd1);
    checkOutput("ldr_rd_rw", 8'(RegWrite), 8'd0);
    applyStimulus(1'b1, LDR, 4'd5, 4'hF);
    checkOutput("ldr_wb_state", 8'(state_dbg), 8'd4);
    checkOutput("ldr_wb_res", 8'(ResultSrc), 8'd1);
    checkOutput("ldr_wb_rw", 8'(RegWrite), 8'd1);
    checkOutput("ldr_wb_pcw", 8'(PCWrite), 8'd0);

    // SUBS immediate with ALU flags 0100 -> Flags=0100, then BEQ taken
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    checkOutput("subs1_fetch_state", 8'(state_dbg), 8'd0);
    checkOutput("subs1_fetch_flags", 8'(Flags), 8'h0);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'h4);
    checkOutput("subs1_exec_state", 8'(state_dbg), 8'd7);
    checkOutput("subs1_exec_aluc", 8'(ALUControl), 8'h1);
    checkOutput("subs1_exec_alub", 8'(ALUSrcB), 8'd1);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    checkOutput("subs1_wb_state", 8'(state_dbg), 8'd8);
    checkOutput("subs1_wb_flags", 8'(Flags), 8'h4);
    applyStimulus(1'b1, BEQ, 4'd0, 4'hF);
    checkOutput("beq1_fetch_flags", 8'(Flags), 8'h4);
    applyStimulus(1'b1, BEQ, 4'd0, 4'hF);
    checkOutput("beq1_dec_state", 8'(state_dbg), 8'd1);
    applyStimulus(1'b1, BEQ, 4'd0, 4'hF);
    checkOutput("beq1_br_state", 8'(state_dbg), 8'd9);
    checkOutput("beq1_br_pcw", 8'(PCWrite), 8'd1);
    checkOutput("beq1_br_res", 8'(ResultSrc), 8'd2);
    checkOutput("beq1_br_regsrc", 8'(RegSrc), 8'd1);
    checkOutput("beq1_br_flags", 8'(Flags), 8'h4);

    // SUBS with ALU flags 0000, then BEQ not taken
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    checkOutput("subs2_fetch_state", 8'(state_dbg), 8'd0);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'h0);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    checkOutput("subs2_wb_flags", 8'(Flags), 8'h0);
    applyStimulus(1'b1, BEQ, 4'd0, 4'hF);
    applyStimulus(1'b1, BEQ, 4'd0, 4'hF);
    applyStimulus(1'b1, BEQ, 4'd0, 4'hF);
    checkOutput("beq2_br_state", 8'(state_dbg), 8'd9);
    checkOutput("beq2_br_pcw", 8'(PCWrite), 8'd0);

    // Set Z, then STRNE must not write memory
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    checkOutput("subs3_fetch_state", 8'(state_dbg), 8'd0);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'h4);
    applyStimulus(1'b1, SUBS_I, 4'd2, 4'hF);
    checkOutput("subs3_wb_flags", 8'(Flags), 8'h4);
    applyStimulus(1'b1, STRNE, 4'd1, 4'hF);
    applyStimulus(1'b1, STRNE, 4'd1, 4'hF);
    applyStimulus(1'b1, STRNE, 4'd1, 4'hF);
    checkOutput("strne1_adr_state", 8'(state_dbg), 8'd2);
    checkOutput("strne1_adr_mw", 8'(MemWrite), 8'd0);
    applyStimulus(1'b1, STRNE, 4'd1, 4'hF);
    checkOutput("strne1_wr_state", 8'(state_dbg), 8'd5);
    checkOutput("strne1_wr_mw", 8'(MemWrite), 8'd0);
    checkOutput("strne1_wr_adrsrc", 8'(AdrSrc), 8'd1);

    // ADDSEQ clears Z during EXEC; its own writeback still happens
    applyStimulus(1'b1, ADDSEQ, 4'd4, 4'hF);
    checkOutput("addseq_fetch_state", 8'(state_dbg), 8'd0);
    applyStimulus(1'b1, ADDSEQ, 4'd4, 4'hF);
    applyStimulus(1'b1, ADDSEQ, 4'd4, 4'h0);
    checkOutput("addseq_exec_state", 8'(state_dbg), 8'd6);
    applyStimulus(1'b1, ADDSEQ, 4'd4, 4'hF);
    checkOutput("addseq_wb_flags", 8'(Flags), 8'h0);
    checkOutput("addseq_wb_rw", 8'(RegWrite), 8'd1);

    // STRNE with Z=0: MemWrite high for exactly the MEMWR cycle
    applyStimulus(1'b1, STRNE, 4'd1, 4'hF);
    checkOutput("strne2_fetch_mw", 8'(MemWrite), 8'd0);
    applyStimulus(1'b1, STRNE, 4'd1, 4'hF);
    checkOutput("strne2_dec_mw", 8'(MemWrite), 8'd0);
    applyStimulus(1'b1, STRNE, 4'd1, 4'hF);
    checkOutput("strne2_adr_mw", 8'(MemWrite), 8'd0);
    checkOutput("strne2_adr_aluc", 8'(ALUControl), 8'h0);
    applyStimulus(1'b1, STRNE, 4'd1, 4'hF);
    checkOutput("strne2_wr_state", 8'(state_dbg), 8'd5);
    checkOutput("strne2_wr_mw", 8'(MemWrite), 8'd1);
    applyStimulus(1'b1, CMP_R, 4'd0, 4'hF);
    checkOutput("strne2_next_state", 8'(state_dbg), 8'd0);
    checkOutput("strne2_next_mw", 8'(MemWrite), 8'd0);

    // CMP loads all of NZCV without S and never writes a register
    applyStimulus(1'b1, CMP_R, 4'd0, 4'hF);
    applyStimulus(1'b1, CMP_R, 4'd0, 4'h9);
    checkOutput("cmp_exec_aluc", 8'(ALUControl), 8'h1);
    applyStimulus(1'b1, CMP_R, 4'd0, 4'hF);
    checkOutput("cmp_wb_state", 8'(state_dbg), 8'd8);
    checkOutput("cmp_wb_flags", 8'(Flags), 8'h9);
    checkOutput("cmp_wb_rw", 8'(RegWrite), 8'd0);

    // ANDS loads N,Z only: N=0 Z=1 from 0110, C=0 V=1 kept -> 0101
    applyStimulus(1'b1, ANDS_R, 4'd6, 4'hF);
    checkOutput("ands_fetch_flags", 8'(Flags), 8'h9);
    applyStimulus(1'b1, ANDS_R, 4'd6, 4'hF);
    applyStimulus(1'b1, ANDS_R, 4'd6, 4'h6);
    checkOutput("ands_exec_aluc", 8'(ALUControl), 8'h2);
    applyStimulus(1'b1, ANDS_R, 4'd6, 4'hF);
    checkOutput("ands_wb_flags", 8'(Flags), 8'h5);
    checkOutput("ands_wb_rw", 8'(RegWrite), 8'd1);

    // LDR interrupted by reset during MEMWB
    applyStimulus(1'b1, LDR, 4'd7, 4'hF);
    checkOutput("ldr2_fetch_flags", 8'(Flags), 8'h5);
    applyStimulus(1'b1, LDR, 4'd7, 4'hF);
    applyStimulus(1'b1, LDR, 4'd7, 4'hF);
    applyStimulus(1'b1, LDR, 4'd7, 4'hF);
    checkOutput("ldr2_rd_state", 8'(state_dbg), 8'd3);
    applyStimulus(1'b0, LDR, 4'd7, 4'hF);
    checkOutput("ldr2_wb_state", 8'(state_dbg), 8'd4);
    checkOutput("ldr2_wb_rw", 8'(RegWrite), 8'd0);
    checkOutput("ldr2_wb_pcw", 8'(PCWrite), 8'd0);
    applyStimulus(1'b1, LDR, 4'd7, 4'hF);
    checkOutput("post_rst_state", 8'(state_dbg), 8'd0);
    checkOutput("post_rst_flags", 8'(Flags), 8'h0);
    checkOutput("post_rst_pcw", 8'(PCWrite), 8'd1);
    checkOutput("post_rst_irw", 8'(IRWrite), 8'd1);
    applyStimulus(1'b1, LDR, 4'd7, 4'hF);
    checkOutput("post_rst_dec_state", 8'(state_dbg), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control unit that sits directly upstream of the datapath and drives all of its select and enable lines.
- Consumes instruction fields {Cond, Op, Funct}, the Rd field, and raw ALU flags.
- Sequences each instruction through a 10-state FSM and holds the architectural NZCV flag register.
- Applies ARM conditional execution to every architectural write.

Parameters:
- STATE_W, 4, width of the FSM state encoding and of the state_dbg port.
- ALUCTRL_W, 4, width of ALUControl.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ctrl_bits  in  12  {Cond[11:8], Op[7:6], Funct[5:0]}.
- rd  in  4  destination register field.
- alu_flags  in  4  {N,Z,C,V} from the ALU this cycle.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction register enable.
- MemWrite  out  1  data memory write enable.
- RegWrite  out  1  register file write enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result.
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALU direct.
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC.
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4.
- RegSrc  out  2  [0]=1 for branch (Op=10); [1]=1 for memory op (Op=01).
- ImmSrc  out  2  equals Op.
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 PASS-B.
- Flags  out  4  registered NZCV.
- state_dbg  out  4  current state.

Behaviour:
- Reset:
  - State, Flags and CondEx take their reset values on the clk edge sampled with reset=0: state=FETCH(0), Flags=0000, CondEx=0.
  - While reset=0, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. Other outputs show the FETCH decode values.
  - Reset asserted mid-instruction discards that instruction. No write occurs in the reset cycle.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9. Codes 10-15 go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH (NOP).
  - MEMADR: Funct[0]=1 -> MEMRD, else MEMWR.
  - MEMRD -> MEMWB -> FETCH. MEMWR -> FETCH.
  - EXECR and EXECI -> ALUWB -> FETCH. BRANCH -> FETCH.
  - Latency: LDR 5 cycles; data-processing 4; STR 4; B 3.
- Per-state outputs (unlisted outputs = 0):
  - FETCH: IRWrite=1, PCWrite=1 (unconditional), ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - MEMADR: ALUSrcB=01; ADD if Funct[3]=1, else SUB.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01; RegWrite=CondEx; PCWrite=CondEx when rd=15.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01.
  - ALUWB: ResultSrc=00; RegWrite=CondEx & ~cmp; PCWrite=CondEx & ~cmp when rd=15.
  - BRANCH: ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
- Data-processing ALU decode in EXECR/EXECI, from Funct[4:1]:
  - 0100 ADD; 0010 SUB; 0000 AND; 1100 ORR; 0001 EOR; 1101 MOV (PASS-B).
  - 1010 CMP: SUB with cmp=1, flags written regardless of S.
  - Any other value: ADD with RegWrite suppressed.
- CondEx:
  - Computed from Cond and the registered Flags; latched at the DECODE->next-state edge.
  - Held constant for the rest of the instruction, so a flag update during EXEC does not alter the same instruction's writeback.
  - Conditions: EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1; 1111 0.
- Flag update:
  - Occurs at the end of an EXECR/EXECI cycle when CondEx & (Funct[0] | cmp).
  - ADD/SUB/CMP load all of NZCV from alu_flags. Logical ops and MOV load N,Z only; C,V hold.
  - Flags are never written in any other state.

Decomposition:
- Package mc_ctrl_pkg: state enum, ALUControl constants, Op and Cond code constants.
- Sub-module cond_unit: Flags register, condition evaluator and CondEx latch, with inputs cond, alu_flags, flag_we_nz, flag_we_cv, latch_en.
- Top level: FSM and output decode.

Test Plan:
- Reset: hold reset=0 for 3 cycles with Op=00 -> all four write enables 0, state_dbg=0, Flags=0000. Release -> PCWrite=1 and IRWrite=1 in the first cycle.
- ADD reg (Cond=1110, Op=00, Funct=001000, rd=3) -> state sequence 0,1,6,8,0. RegWrite=1 only in ALUWB. ALUControl=0000 in EXECR.
- LDR (Op=01, Funct=011001) -> sequence 0,1,2,3,4,0. AdrSrc=1 in MEMRD. MemtoReg path ResultSrc=01 and RegWrite=1 in MEMWB.
- SUBS with alu_flags=0100 in EXECI, then BEQ (Cond=0000, Op=10) -> Flags=0100; PCWrite=1 in BRANCH. Repeat with flags 0000 -> PCWrite=0 in BRANCH.
- STRNE with Flags Z=1 -> MemWrite stays 0 through MEMWR. Same instruction with Z=0 -> MemWrite=1 for exactly one cycle.
- Reset=0 asserted in MEMWB -> RegWrite=0 that cycle; next state FETCH.
